// File: rtl/key_loader_32.sv
// key_loader_32: serial LSB-first loader for a 32-bit locking key.
// Bits are gathered in a shadow register. key_out only changes when a
// complete frame passes its check, on key_clr, or on reset.
// Optional feature: define KEY_LOADER_PARITY_EN to append one even-parity
// bit to each frame (33-bit frames). CHECK then passes only if the XOR of
// all 33 bits is 0.
module key_loader_32 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        key_clr,
  input  logic        key_sdi,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [31:0] key_out,
  output logic        key_loaded,
  output logic        load_err
);

`ifdef KEY_LOADER_PARITY_EN
  localparam int unsigned FrameLen = 33;
`else
  localparam int unsigned FrameLen = 32;
`endif

  localparam logic [5:0] LastBit = 6'(FrameLen - 1);
  localparam logic [7:0] ToLast  = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e      state;
  logic [5:0]  bit_cnt;
  logic [7:0]  to_cnt;
  logic [31:0] shadow;
  logic        check_pass;
  logic        accept;

  // Ready is a pure decode of the state register.
  assign key_ready = (state == StShift);

  // A bit is taken only when no clear or restart overrides the cycle.
  assign accept = key_ready && key_valid && !key_clr && !load_start;

`ifdef KEY_LOADER_PARITY_EN
  logic par;

  // Running XOR of every accepted bit in the current frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= 1'b0;
    end else if (key_clr || load_start) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= par ^ key_sdi;
    end
  end

  assign check_pass = ~par;
`else
  assign check_pass = 1'b1;
`endif

  // Frame control FSM with registered outputs.
  // Priority: key_clr, then load_start, then the normal per-state action.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      shadow     <= '0;
      key_out    <= '0;
      key_loaded <= 1'b0;
      load_err   <= 1'b0;
    end else if (key_clr) begin
      state      <= StIdle;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      shadow     <= '0;
      key_out    <= '0;
      key_loaded <= 1'b0;
    end else if (load_start) begin
      // Starts a frame from any state and discards partial bits.
      state      <= StShift;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      shadow     <= '0;
      key_loaded <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      unique case (state)
        StShift: begin
          if (accept) begin
            to_cnt <= '0;
            // The parity bit (index 32) is never stored in the shadow.
            if (!bit_cnt[5]) begin
              shadow[bit_cnt[4:0]] <= key_sdi;
            end
            if (bit_cnt == LastBit) begin
              state <= StCheck;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end else if (to_cnt == ToLast) begin
            state    <= StError;
            load_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        StCheck: begin
          if (check_pass) begin
            key_out    <= shadow;
            key_loaded <= 1'b1;
            state      <= StDone;
          end else begin
            load_err <= 1'b1;
            state    <= StError;
          end
        end
        default: begin
          // IDLE, DONE and ERROR hold until load_start or key_clr.
        end
      endcase
    end
  end

endmodule

// File: doc/key_loader_32.md
KEY_LOADER_32 -- requirements
Module: key_loader_32

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the max idle cycles between accepted bits mid-frame (1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port load_start, input, 1 bit: single-cycle pulse that begins a key frame.
REQ-005 SHALL have port key_clr, input, 1 bit: single-cycle pulse that zeroes the delivered key.
REQ-006 SHALL have port key_sdi, input, 1 bit: serial key data.
REQ-007 SHALL have port key_valid, input, 1 bit: key_sdi is valid this cycle.
REQ-008 SHALL have port key_ready, output, 1 bit: loader accepts a bit this cycle.
REQ-009 SHALL have port key_out, output, 32 bits: delivered key; bit i drives locked-netlist input keyIn_0_i.
REQ-010 SHALL have port key_loaded, output, 1 bit: key_out holds a verified key.
REQ-011 SHALL have port load_err, output, 1 bit: last frame failed.

Function
REQ-012 SHALL implement states IDLE, SHIFT, CHECK, DONE, ERROR.
REQ-013 SHALL accept a bit only on a cycle with key_valid=1 and key_ready=1; key_ready SHALL be 1 only in SHIFT.
REQ-014 SHALL move IDLE/DONE/ERROR -> SHIFT on load_start, clearing a 6-bit bit counter, the shadow register and the timeout counter, and clearing load_err.
REQ-015 SHALL shift LSB first: the k-th accepted bit (k=0..31) is written to shadow bit k.
REQ-016 SHALL move SHIFT -> CHECK on the cycle after the final frame bit is accepted (bit 31, or the parity bit when parity is compiled in).
REQ-017 SHALL, in CHECK (one cycle), on pass copy the shadow to key_out atomically, set key_loaded=1 and go to DONE; on fail leave key_out unchanged, set load_err=1 and go to ERROR.
REQ-018 SHALL never present a partially loaded key on key_out; key_out SHALL change only in CHECK-pass, key_clr or reset.
REQ-019 SHALL count consecutive SHIFT cycles without an accepted bit, and on reaching TIMEOUT go to ERROR with load_err=1, leaving key_out unchanged.
REQ-020 SHALL restart the frame (as REQ-014) on load_start arriving while in SHIFT or CHECK, discarding received bits.
REQ-021 SHALL, on key_clr in any state, zero key_out and key_loaded and go to IDLE; key_clr SHALL take priority over a simultaneous load_start.
REQ-022 SHALL, while in DONE, keep key_out and key_loaded=1 and ignore key_valid.
REQ-023 SHALL clear key_loaded when a new frame starts (REQ-014); key_out SHALL keep the old key until the new frame passes CHECK.

Reset
REQ-024 SHALL, on rst=1, immediately force state IDLE, key_out=32'h0, key_loaded=0, load_err=0, key_ready=0, and clear all counters and the shadow register.
REQ-025 SHALL abort any frame in progress when rst asserts mid-frame; after release the loader SHALL wait in IDLE for load_start.

Configuration
REQ-026 SHALL use macro KEY_LOADER_PARITY_EN. When defined, the frame is 33 bits: 32 key bits then 1 even-parity bit, and CHECK passes only if the XOR of all 33 bits is 0. When undefined, the frame is 32 bits and CHECK always passes.

Verification
REQ-027 SHALL cover this: rst, load_start, 32 bits of 32'hA5C3_0F71 LSB-first, plus parity 0 when enabled -> key_out=32'hA5C3_0F71 and key_loaded=1 one cycle after the final bit; load_err=0.
REQ-028 SHALL cover this (parity enabled): the same key with parity bit 1 -> load_err=1, key_loaded=0, key_out=0.
REQ-029 SHALL cover this: load a key, then start a new frame and stall key_valid for TIMEOUT cycles after bit 10 -> load_err=1, key_out still holds the old key, key_loaded=0.
REQ-030 SHALL cover this: load_start again after bit 20, then a full 32'h0000_FFFF frame -> key_out=32'h0000_FFFF; no bits from the first frame appear.
REQ-031 SHALL cover this: key_clr and load_start in the same cycle while in DONE -> key_out=0, key_loaded=0, state IDLE, key_ready=0.
REQ-032 SHALL cover this: rst asserted asynchronously between clock edges during SHIFT -> all outputs are zero before the next clk edge.
